// File: rtl/boot_copier.sv
// Boot ROM to destination memory copier with registered-ROM latency handling.
// Optional image checksum check enabled by BOOT_COPIER_CHECKSUM_EN.
module boot_copier #(
   parameter int          ROM_AW    = 9,
   parameter int          COUNT     = 512,
   parameter int          DEST_AW   = 16,
   parameter int unsigned DEST_BASE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ROM_AW-1:0]  rom_addr,
   input  logic [7:0]         rom_rddata,
   output logic [DEST_AW-1:0] dst_addr,
   output logic [7:0]         dst_wrdata,
   output logic               dst_wr,
   input  logic               dst_ready,
   output logic               busy,
   output logic               done,
   output logic               checksum_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LATCH = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // One extra index bit so a full 2**ROM_AW image never wraps.
   localparam logic [ROM_AW:0] LAST = (ROM_AW+1)'(COUNT - 1);

   logic [2:0]      state_q, state_d;
   logic [ROM_AW:0] index_q, index_d;
   logic [7:0]      wrdata_q, wrdata_d;
   logic            wr_q, wr_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef BOOT_COPIER_CHECKSUM_EN
   logic [7:0]      acc_q, acc_d;
   logic            err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      wrdata_d = wrdata_q;
      wr_d     = wr_q;
      busy_d   = busy_q;
      done_d   = done_q;
`ifdef BOOT_COPIER_CHECKSUM_EN
      acc_d    = acc_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FETCH;
               index_d = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
`ifdef BOOT_COPIER_CHECKSUM_EN
               acc_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            wrdata_d = rom_rddata;
            wr_d     = 1'b1;
            state_d  = S_WRITE;
`ifdef BOOT_COPIER_CHECKSUM_EN
            acc_d    = acc_q + rom_rddata;
`endif
         end
         S_WRITE: begin
            if (dst_ready) begin
               wr_d = 1'b0;
               if (index_q == LAST) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
`ifdef BOOT_COPIER_CHECKSUM_EN
                  err_d   = |acc_q;
`endif
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         index_q  <= '0;
         wrdata_q <= '0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BOOT_COPIER_CHECKSUM_EN
         acc_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         wrdata_q <= wrdata_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef BOOT_COPIER_CHECKSUM_EN
         acc_q    <= acc_d;
         err_q    <= err_d;
`endif
      end
   end

   assign rom_addr   = index_q[ROM_AW-1:0];
   assign dst_addr   = DEST_AW'(DEST_BASE) + DEST_AW'(index_q);
   assign dst_wrdata = wrdata_q;
   assign dst_wr     = wr_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef BOOT_COPIER_CHECKSUM_EN
   assign checksum_err = err_q;
`else
   assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// Randomized scoreboard bench for boot_copier: a full 512-byte instance
// and a small 4-byte instance with a wrapping destination base.
module tb_boot_copier;

   localparam int N = 512;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        start = 0;
   logic        s_start = 0;
   logic        dst_ready = 1;
   logic [8:0]  rom_addr, s_rom_addr;
   logic [7:0]  rom_rddata = 0, s_rom_rddata = 0;
   logic [15:0] dst_addr, s_dst_addr;
   logic [7:0]  dst_wrdata, s_dst_wrdata;
   logic        dst_wr, busy, done, checksum_err;
   logic        s_dst_wr, s_busy, s_done, s_checksum_err;

   logic [7:0]  mem [N];
   wr_t         sb[$];
   wr_t         s_sb[$];
   int          pass_cnt = 0;
   int          tot_cnt = 0;
   int          wr_cnt = 0;
   bit          hold_v = 0;
   logic [15:0] hold_a;
   logic [7:0]  hold_d;

   always #5 clk = ~clk;

   boot_copier dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_addr(rom_addr), .rom_rddata(rom_rddata),
      .dst_addr(dst_addr), .dst_wrdata(dst_wrdata),
      .dst_wr(dst_wr), .dst_ready(dst_ready),
      .busy(busy), .done(done), .checksum_err(checksum_err)
   );

   boot_copier #(.COUNT(4), .DEST_BASE(16'hFFFE)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start),
      .rom_addr(s_rom_addr), .rom_rddata(s_rom_rddata),
      .dst_addr(s_dst_addr), .dst_wrdata(s_dst_wrdata),
      .dst_wr(s_dst_wr), .dst_ready(1'b1),
      .busy(s_busy), .done(s_done), .checksum_err(s_checksum_err)
   );

   // Registered-read boot ROM models
   always @(posedge clk) begin
      rom_rddata   <= mem[rom_addr];
      s_rom_rddata <= mem[s_rom_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // Monitor: pop expected writes on each accepted transfer
   initial forever begin
      wr_t e;
      @(negedge clk);
      if (rst_n && dst_wr) begin
         if (hold_v) begin
            chk("hold_addr", dst_addr, hold_a);
            chk("hold_data", dst_wrdata, hold_d);
         end
         if (dst_ready) begin
            hold_v = 0;
            wr_cnt++;
            if (sb.size() == 0) chk("extra_write", 1, 0);
            else begin
               e = sb.pop_front();
               chk("wr_addr", dst_addr, e.a);
               chk("wr_data", dst_wrdata, e.d);
            end
         end else begin
            hold_v = 1;
            hold_a = dst_addr;
            hold_d = dst_wrdata;
         end
      end else hold_v = 0;
   end

   initial forever begin
      wr_t e;
      @(negedge clk);
      if (rst_n && s_dst_wr) begin
         if (s_sb.size() == 0) chk("s_extra_write", 1, 0);
         else begin
            e = s_sb.pop_front();
            chk("s_wr_addr", s_dst_addr, e.a);
            chk("s_wr_data", s_dst_wrdata, e.d);
         end
      end
   end

   function automatic logic exp_err();
      logic [7:0] s;
      s = 0;
`ifdef BOOT_COPIER_CHECKSUM_EN
      for (int i = 0; i < N; i++) s += mem[i];
`endif
      return s != 0;
   endfunction

   function automatic void push_all();
      for (int i = 0; i < N; i++) begin
         wr_t e;
         e.a = 16'(i);
         e.d = mem[i];
         sb.push_back(e);
      end
   endfunction

   // mode 0: ready=1; 1: random ready; 2: spurious starts
   task automatic run_copy(input int mode, input int bp, output int cyc);
      int bp_left;
      bit bp_done, sp1, sp2;
      logic err;
      bp_left = 0; bp_done = 0; sp1 = 0; sp2 = 0;
      err = exp_err();
      push_all();
      wr_cnt = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      chk("start_done_low", done, 0);
      chk("start_busy", busy, 1);
      cyc = 0;
      forever begin
         @(posedge clk); cyc++; #1 start = 0;
         if (done) break;
         if (cyc > 20000) begin chk("timeout", 0, 1); break; end
         if (bp >= 0 && !bp_done && dst_wr && dst_addr == 16'(bp)) begin
            bp_left = 5; bp_done = 1;
         end
         if (bp_left > 0) begin dst_ready = 0; bp_left--; end
         else if (mode == 1) dst_ready = ($urandom_range(0, 3) != 0);
         else dst_ready = 1;
         if (mode == 2 && !sp1 && wr_cnt == 10) begin start = 1; sp1 = 1; end
         if (mode == 2 && !sp2 && wr_cnt == 200) begin start = 1; sp2 = 1; end
      end
      dst_ready = 1;
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_cks", checksum_err, err);
      chk("write_count", wr_cnt, N);
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'hA5;
      #12;
      chk("rst_addr", dst_addr, 0);
      chk("rst_wr", dst_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("s_rst_addr", s_dst_addr, 16'hFFFE);
      rst_n = 1;

      // small image with wrapping destination addresses
      for (int i = 0; i < 4; i++) begin
         wr_t e;
         e.a = 16'hFFFE + 16'(i);
         e.d = mem[i];
         s_sb.push_back(e);
      end
      @(posedge clk); #1 s_start = 1;
      @(posedge clk); #1 s_start = 0;
      cyc = 0;
      while (!s_done && cyc < 100) begin @(posedge clk); cyc++; #1; end
      chk("s_cycles", cyc, 12);
      chk("s_sb_empty", s_sb.size(), 0);

      run_copy(0, -1, cyc);
      chk("full_cycles", cyc, 3 * N);
      run_copy(0, 3, cyc);
      run_copy(2, -1, cyc);

      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      run_copy(1, -1, cyc);

      // reset while byte 100 is pending
      push_all();
      wr_cnt = 0;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      cyc = 0;
      while (!(dst_wr && wr_cnt == 100) && cyc < 2000) begin
         @(posedge clk); cyc++; #1;
      end
      chk("pre_rst_addr", dst_addr, 100);
      dst_ready = 0;
      #1 rst_n = 0;
      #1;
      chk("mid_rst_rom", rom_addr, 0);
      chk("mid_rst_addr", dst_addr, 0);
      chk("mid_rst_data", dst_wrdata, 0);
      chk("mid_rst_wr", dst_wr, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_cks", checksum_err, 0);
      sb.delete();
      @(posedge clk); #1 rst_n = 1; dst_ready = 1;
      run_copy(1, -1, cyc);

      // checksum images: good then corrupted
      for (int i = 0; i < N; i++) mem[i] = 8'h01;
      run_copy(0, -1, cyc);
      mem[N-1] = 8'h02;
      run_copy(0, -1, cyc);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
